ahb_master_ctrl: RTL and testbench

AHB_MASTER_CTRL -- requirements
Module: ahb_master_ctrl

---
 rtl/ahb_master_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ahb_master_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_ctrl.sv
// Single-outstanding AHB-Lite master: turns one local command into one NONSEQ transfer.
// Build option AHB_MASTER_ERR_RETRY_EN: reissue a transfer once after its first ERROR response.
module ahb_master_ctrl (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_write,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  htrans,
    output logic [6:0]  haddr,
    output logic [1:0]  hsize,
    output logic        hwrite,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_r, state_s;
    logic        cmd_ready_r, cmd_ready_s;
    logic [1:0]  htrans_r, htrans_s;
    logic [6:0]  haddr_r, haddr_s;
    logic [1:0]  hsize_r, hsize_s;
    logic        hwrite_r, hwrite_s;
    logic [31:0] hwdata_r, hwdata_s;
    logic [31:0] wdata_r, wdata_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_err_r, rsp_err_s;
    logic        accept_s;
    logic        err_end_s;
    logic        retry_go_s;

    assign accept_s = (state_r == ST_IDLE) && cmd_valid;

    // An ERROR response ends with hready high; hready+hresp straight out of DATA counts too.
    assign err_end_s = ((state_r == ST_DATA) && hready && hresp) ||
                       ((state_r == ST_ERR)  && hready);

`ifdef AHB_MASTER_ERR_RETRY_EN
    logic retry_r;

    // Remembers whether the current command has already used its one reissue.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            retry_r <= 1'b0;
        end else if (accept_s) begin
            retry_r <= 1'b0;
        end else if (retry_go_s) begin
            retry_r <= 1'b1;
        end else begin
            retry_r <= retry_r;
        end
    end

    assign retry_go_s = err_end_s && !retry_r;
`else
    assign retry_go_s = 1'b0;
`endif

    // Next-state and next-output decode; every bus output is registered from these values.
    always_comb begin
        state_s     = state_r;
        haddr_s     = haddr_r;
        hsize_s     = hsize_r;
        hwrite_s    = hwrite_r;
        wdata_s     = wdata_r;
        hwdata_s    = hwdata_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s  = ST_ADDR;
                    haddr_s  = cmd_addr;
                    hsize_s  = cmd_size;
                    hwrite_s = cmd_write;
                    wdata_s  = cmd_wdata;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    state_s  = ST_DATA;
                    hwdata_s = hwrite_r ? wdata_r : 32'h0000_0000;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (retry_go_s) begin
                    state_s = ST_ADDR;
                end else if (err_end_s) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = 32'h0000_0000;
                end else if (hready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b1;
                    if (!hwrite_r) begin
                        rsp_rdata_s = hrdata;
                    end else begin
                        rsp_rdata_s = rsp_rdata_r;
                    end
                end else if (hresp) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_ERR: begin
                if (retry_go_s) begin
                    state_s = ST_ADDR;
                end else if (hready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = 32'h0000_0000;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_s = (state_s == ST_IDLE);
    assign htrans_s    = (state_s == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

    // State and output registers; reset abandons any transfer in flight without a response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            htrans_r    <= HTRANS_IDLE;
            haddr_r     <= 7'h00;
            hsize_r     <= 2'b00;
            hwrite_r    <= 1'b0;
            hwdata_r    <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            htrans_r    <= htrans_s;
            haddr_r     <= haddr_s;
            hsize_r     <= hsize_s;
            hwrite_r    <= hwrite_s;
            hwdata_r    <= hwdata_s;
            wdata_r     <= wdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign htrans    = htrans_r;
    assign haddr     = haddr_r;
    assign hsize     = hsize_r;
    assign hwrite    = hwrite_r;
    assign hwdata    = hwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Scoreboard bench for ahb_master_ctrl: the bench plays the AHB slave cycle by cycle.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_ahb_master_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [1:0]  cmd_size;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  htrans;
    logic [6:0]  haddr;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_r;
    int   n_cmp = 0;
    int   n_bad = 0;

    ahb_master_ctrl dut (
        .clk(clk), .n_rst(n_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_size(cmd_size), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .htrans(htrans), .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(negedge clk);
    endtask

    // Presents a command for the coming edge and records its expected response.
    task automatic issue(input logic [6:0] a, input logic [1:0] s, input logic w,
                         input logic [31:0] wd, input logic [31:0] rd, input logic e, input logic c);
        cmd_valid = 1'b1; cmd_addr = a; cmd_size = s; cmd_write = w; cmd_wdata = wd;
        sb.push_back('{rd, e, c});
    endtask

    task automatic test_reset;
        n_rst = 1'b0; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_size = 2'b00; cmd_write = 1'b0;
        cmd_wdata = 32'h0; hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
        repeat (2) cyc;
        n_cmp++;
        if ({cmd_ready, htrans, haddr, hsize, hwrite, hwdata, rsp_valid, rsp_rdata, rsp_err} !==
            {1'b1, 2'b00, 7'h00, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL reset_hold: got rdy=%b tr=%b a=%h wd=%h rv=%b", cmd_ready, htrans, haddr, hwdata, rsp_valid);
        end
        n_rst = 1'b1;
        cyc;
        n_cmp++;
        if ({cmd_ready, htrans, rsp_valid, rsp_err} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_release: got rdy=%b tr=%b rv=%b want 1 00 0", cmd_ready, htrans, rsp_valid);
        end
    endtask

    task automatic test_read;
        issue(7'h40, 2'b00, 1'b0, 32'h1111_1111, 32'h0000_00A5, 1'b0, 1'b1);
        hrdata = 32'hFFFF_FFFF;
        cyc;  // cycle 1: address phase
        cmd_valid = 1'b0;
        n_cmp++;
        if ({cmd_ready, htrans, haddr, hsize, hwrite, rsp_valid} !== {1'b0, 2'b10, 7'h40, 2'b00, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL read_addr: got rdy=%b tr=%b a=%h s=%b w=%b", cmd_ready, htrans, haddr, hsize, hwrite);
        end
        hready = 1'b1;
        cyc;  // cycle 2: data phase
        n_cmp++;
        if ({htrans, hwdata, cmd_ready, rsp_valid} !== {2'b00, 32'h0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL read_data: got tr=%b wd=%h rdy=%b rv=%b", htrans, hwdata, cmd_ready, rsp_valid);
        end
        hrdata = 32'h0000_00A5;
        cyc;  // cycle 3: response
        hrdata = 32'hFFFF_FFFF;
        n_cmp++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL read_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp_r = sb.pop_front();
            if ({rsp_rdata, rsp_err} !== {exp_r.rdata, exp_r.err}) begin
                n_bad++; $display("FAIL read_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
            end
        end
        cyc;
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b0, 32'h0000_00A5, 1'b0}) begin
            n_bad++; $display("FAIL read_hold: got rv=%b rd=%h err=%b want 0 000000a5 0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_write_wait;
        issue(7'h00, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        cyc;  // cycle 1: address phase
        cmd_valid = 1'b0;
        n_cmp++;
        if ({htrans, haddr, hsize, hwrite} !== {2'b10, 7'h00, 2'b10, 1'b1}) begin
            n_bad++; $display("FAIL write_addr: got tr=%b a=%h s=%b w=%b", htrans, haddr, hsize, hwrite);
        end
        hready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            cyc;  // cycles 2..4: data phase, two wait states
            n_cmp++;
            if ({htrans, hwdata, rsp_valid} !== {2'b00, 32'hDEAD_BEEF, 1'b0}) begin
                n_bad++; $display("FAIL write_data%0d: got tr=%b wd=%h rv=%b", w, htrans, hwdata, rsp_valid);
            end
            hready = (w == 2);
        end
        cyc;  // cycle 5: response
        n_cmp++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL write_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp_r = sb.pop_front();
            if (rsp_err !== exp_r.err) begin
                n_bad++; $display("FAIL write_rsp_err: got %b want %b", rsp_err, exp_r.err);
            end
        end
        hready = 1'b1;
    endtask

    task automatic test_error;
        issue(7'h48, 2'b01, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b1);
        cyc;  // cycle 1: address phase
        cmd_valid = 1'b0;
        hready = 1'b1; hresp = 1'b0;
        cyc;  // cycle 2: data phase, first ERROR cycle
        n_cmp++;
        if ({htrans, hwdata} !== {2'b00, 32'h0BAD_F00D}) begin
            n_bad++; $display("FAIL err_data: got tr=%b wd=%h", htrans, hwdata);
        end
        hready = 1'b0; hresp = 1'b1;
        cyc;  // cycle 3: second ERROR cycle
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_early: got rv=%b want 0", rsp_valid);
        end
        hready = 1'b1; hresp = 1'b1;
        cyc;
`ifdef AHB_MASTER_ERR_RETRY_EN
        n_cmp++;
        if ({htrans, haddr, hwrite, rsp_valid} !== {2'b10, 7'h48, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL err_retry_addr: got tr=%b a=%h rv=%b", htrans, haddr, rsp_valid);
        end
        hready = 1'b1; hresp = 1'b0;
        cyc;
        hready = 1'b0; hresp = 1'b1;
        cyc;
        hready = 1'b1; hresp = 1'b1;
        cyc;
`endif
        hready = 1'b1; hresp = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL err_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp_r = sb.pop_front();
            if ({rsp_rdata, rsp_err} !== {exp_r.rdata, exp_r.err}) begin
                n_bad++; $display("FAIL err_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
            end
        end
        cyc;
        n_cmp++;
        if ({rsp_valid, rsp_err} !== {1'b0, 1'b0}) begin
            n_bad++; $display("FAIL err_clear: got rv=%b err=%b want 0 0", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_err_violation;
`ifdef AHB_MASTER_ERR_RETRY_EN
        issue(7'h10, 2'b10, 1'b0, 32'h0, 32'h5A5A_0001, 1'b0, 1'b1);
`else
        issue(7'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
`endif
        cyc;
        cmd_valid = 1'b0;
        hready = 1'b1; hresp = 1'b0;
        cyc;  // data phase ends with hready and hresp both high
        hready = 1'b1; hresp = 1'b1; hrdata = 32'h7777_7777;
        cyc;
`ifdef AHB_MASTER_ERR_RETRY_EN
        n_cmp++;
        if ({htrans, haddr, rsp_valid} !== {2'b10, 7'h10, 1'b0}) begin
            n_bad++; $display("FAIL viol_retry_addr: got tr=%b a=%h rv=%b", htrans, haddr, rsp_valid);
        end
        hready = 1'b1; hresp = 1'b0;
        cyc;
        hrdata = 32'h5A5A_0001;
        cyc;
`endif
        hready = 1'b1; hresp = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL viol_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp_r = sb.pop_front();
            if ({rsp_rdata, rsp_err} !== {exp_r.rdata, exp_r.err}) begin
                n_bad++; $display("FAIL viol_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
            end
        end
        cyc;
    endtask

    task automatic test_addr_stall;
        issue(7'h7F, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
        cyc;
        cmd_addr = 7'h05; cmd_size = 2'b01; cmd_write = 1'b1;  // not accepted while busy
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({cmd_ready, htrans, haddr, hsize, hwrite} !== {1'b0, 2'b10, 7'h7F, 2'b10, 1'b0}) begin
                n_bad++; $display("FAIL stall_addr%0d: got rdy=%b tr=%b a=%h s=%b w=%b", k, cmd_ready, htrans, haddr, hsize, hwrite);
            end
            hready = (k == 2);
            if (k == 2) cmd_valid = 1'b0;
            cyc;
        end
        n_cmp++;
        if ({htrans, cmd_ready} !== {2'b00, 1'b0}) begin
            n_bad++; $display("FAIL stall_data: got tr=%b rdy=%b", htrans, cmd_ready);
        end
        hready = 1'b1; hrdata = 32'h1234_5678;
        cyc;
        n_cmp++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL stall_rsp_valid: got %b want 1", rsp_valid);
        end else begin
            exp_r = sb.pop_front();
            if ({rsp_rdata, rsp_err} !== {exp_r.rdata, exp_r.err}) begin
                n_bad++; $display("FAIL stall_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
            end
        end
        cyc;
    endtask

    task automatic test_reset_mid;
        int seen;
        issue(7'h20, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc;
        cmd_valid = 1'b0; hready = 1'b1;
        cyc;  // data phase, slave waits
        hready = 1'b0;
        cyc;
        n_rst = 1'b0;
        sb.delete();
        #1;
        n_cmp++;
        if ({cmd_ready, htrans, haddr, hsize, hwrite, hwdata, rsp_valid, rsp_rdata, rsp_err} !==
            {1'b1, 2'b00, 7'h00, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL midrst_vals: got rdy=%b tr=%b a=%h rv=%b rd=%h", cmd_ready, htrans, haddr, rsp_valid, rsp_rdata);
        end
        seen = 0;
        hready = 1'b1;
        repeat (2) begin cyc; seen += int'(rsp_valid); end
        n_rst = 1'b1;
        repeat (2) begin cyc; seen += int'(rsp_valid); end
        n_cmp++;
        if (seen != 0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_norsp: got pulses=%0d rdy=%b want 0 1", seen, cmd_ready);
        end
        issue(7'h24, 2'b00, 1'b0, 32'h0, 32'h0000_3C3C, 1'b0, 1'b1);
        cyc;
        cmd_valid = 1'b0; hready = 1'b1;
        cyc;
        hrdata = 32'h0000_3C3C;
        cyc;
        n_cmp++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL midrst_after: got rv=%b want 1", rsp_valid);
        end else begin
            exp_r = sb.pop_front();
            if ({rsp_rdata, rsp_err} !== {exp_r.rdata, exp_r.err}) begin
                n_bad++; $display("FAIL midrst_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
            end
        end
        cyc;
    endtask

    task automatic test_back_to_back;
        int n_acc = 0;
        int n_ns  = 0;
        int n_rsp = 0;
        hready = 1'b1; hresp = 1'b0; cmd_size = 2'b10; cmd_write = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_rsp: got response %0d with empty scoreboard", n_rsp);
                end else begin
                    exp_r = sb.pop_front();
                    if ({rsp_rdata, rsp_err} !== {exp_r.rdata, exp_r.err}) begin
                        n_bad++; $display("FAIL b2b_rsp%0d: got %h/%b want %h/%b", n_rsp, rsp_rdata, rsp_err, exp_r.rdata, exp_r.err);
                    end
                end
            end
            if (htrans === 2'b10) begin
                n_ns++;
                n_cmp++;
                if (cmd_ready !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_ready_busy: got %b want 0", cmd_ready);
                end
            end else if (cmd_ready === 1'b0) begin
                hrdata = 32'hC0DE_0000 + 32'(n_ns - 1);
            end else begin
                hrdata = 32'hFFFF_FFFF;
            end
            cmd_valid = (n_acc < 4);
            cmd_addr  = 7'(7'h30 + n_acc);
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{32'hC0DE_0000 + 32'(n_acc), 1'b0, 1'b1});
                n_acc++;
            end
            cyc;
        end
        n_cmp++;
        if (n_acc != 4 || n_ns != 4 || n_rsp != 4 || sb.size() != 0) begin
            n_bad++; $display("FAIL b2b_counts: got acc=%0d nonseq=%0d rsp=%0d left=%0d want 4 4 4 0", n_acc, n_ns, n_rsp, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_error();
        test_err_violation();
        test_addr_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
